// File: rtl/ripple_count_monitor_if.sv
// ripple_count_monitor_if
// Bundles the monitor's data-path signals so the consumer block and its
// environment connect through one port.
//
// Signals:
//   count_in    raw ripple counter value, asynchronous to the monitor clock
//   clr         synchronous one-cycle clear of wraps and step_err
//   count_out   last accepted stable count
//   new_val     one-cycle strobe, high on the cycle count_out takes a new value
//   wraps       number of all-ones -> zero transitions seen, modulo 2^WRAP_W
//   step_err    sticky flag: an accepted value did not follow its predecessor
//   hex_count   active-low 7-segment pattern of count_out[3:0]
//   hex_wrap_lo active-low 7-segment pattern of wraps[3:0]
//   hex_wrap_hi active-low 7-segment pattern of wraps[7:4]
//
// Handshake: there is no valid/ready pair on this block. new_val is a pure
// strobe with no backpressure; count_out is valid from the cycle new_val is
// high and holds until the next new_val. A consumer that misses the strobe
// still sees the current value on count_out.
//
// Modports:
//   master - environment side (drives count_in/clr, observes results)
//   slave  - monitor side (consumes count_in/clr, drives results)

interface ripple_count_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);
  logic [WIDTH-1:0]  count_in;
  logic              clr;
  logic [WIDTH-1:0]  count_out;
  logic              new_val;
  logic [WRAP_W-1:0] wraps;
  logic              step_err;
  logic [6:0]        hex_count;
  logic [6:0]        hex_wrap_lo;
  logic [6:0]        hex_wrap_hi;

  modport master (
    output count_in,
    output clr,
    input  count_out,
    input  new_val,
    input  wraps,
    input  step_err,
    input  hex_count,
    input  hex_wrap_lo,
    input  hex_wrap_hi
  );

  modport slave (
    input  count_in,
    input  clr,
    output count_out,
    output new_val,
    output wraps,
    output step_err,
    output hex_count,
    output hex_wrap_lo,
    output hex_wrap_hi
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor
// Consumer of a ripple up-counter running on a divided clock. The counter
// bits settle one after another, so its output is glitchy and asynchronous
// to clk. This block synchronizes the count with two flops, waits until the
// synchronized value has been steady long enough, publishes it as a clean
// count, counts all-ones -> zero wrap-arounds and drives three 7-segment
// digits (count, wraps low nibble, wraps high nibble).
//
// Parameters:
//   WIDTH         width of the monitored count (hex decode uses the low 4 bits)
//   STABLE_CYCLES consecutive equal synchronized samples before accept (2..255)
//   WRAP_W        width of the wrap counter
//
// Ports:
//   clk    monitor clock (CLOCK_50 domain)
//   reset  synchronous, active-low reset
//   mon    ripple_count_monitor_if.slave (count_in, clr in; results out)
//
// Build option:
//   RIPPLE_SEQ_CHECK_EN - when defined, step_err sets whenever an accepted
//   value is not the previous accepted value + 1. When undefined no step
//   checking is built and step_err is tied low.

module ripple_count_monitor #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int WRAP_W        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  ripple_count_monitor_if.slave  mon
);

  // stab_cnt saturates here; with s2 == cand this marks a settled value.
  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]  s1_q, s1_d;
  logic [WIDTH-1:0]  s2_q, s2_d;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic [7:0]        stab_cnt_q, stab_cnt_d;
  logic [WIDTH-1:0]  count_out_q, count_out_d;
  logic              new_val_q, new_val_d;
  logic              primed_q, primed_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              accept;
  logic [7:0]        wraps_8;
`ifdef RIPPLE_SEQ_CHECK_EN
  logic              step_err_q, step_err_d;
  logic [WIDTH-1:0]  prev_inc;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  always_comb begin
    s1_d        = mon.count_in;
    s2_d        = s1_q;
    cand_d      = cand_q;
    stab_cnt_d  = stab_cnt_q;
    count_out_d = count_out_q;
    new_val_d   = 1'b0;
    primed_d    = primed_q;
    wraps_d     = wraps_q;
    accept      = 1'b0;
`ifdef RIPPLE_SEQ_CHECK_EN
    step_err_d  = step_err_q;
    prev_inc    = count_out_q + WIDTH'(1);
`endif

    // Settle filter: any change in the synchronized value restarts the wait.
    // Once settled, stab_cnt holds; re-accepting is suppressed by comparing
    // against the published value, so a steady input yields one pulse.
    if (s2_q != cand_q) begin
      cand_d     = s2_q;
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q < STAB_MAX) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end else begin
      accept = !primed_q || (cand_q != count_out_q);
    end

    if (accept) begin
      count_out_d = cand_q;
      new_val_d   = 1'b1;
      primed_d    = 1'b1;
      // The very first value after reset has no predecessor to compare with.
      if (primed_q) begin
        if ((count_out_q == '1) && (cand_q == '0)) begin
          wraps_d = wraps_q + WRAP_W'(1);
        end
`ifdef RIPPLE_SEQ_CHECK_EN
        if (cand_q != prev_inc) begin
          step_err_d = 1'b1;
        end
`endif
      end
    end

    // clr overrides any same-edge wrap increment or step error.
    if (mon.clr) begin
      wraps_d = '0;
`ifdef RIPPLE_SEQ_CHECK_EN
      step_err_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      cand_q      <= '0;
      stab_cnt_q  <= 8'd0;
      count_out_q <= '0;
      new_val_q   <= 1'b0;
      primed_q    <= 1'b0;
      wraps_q     <= '0;
`ifdef RIPPLE_SEQ_CHECK_EN
      step_err_q  <= 1'b0;
`endif
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cand_q      <= cand_d;
      stab_cnt_q  <= stab_cnt_d;
      count_out_q <= count_out_d;
      new_val_q   <= new_val_d;
      primed_q    <= primed_d;
      wraps_q     <= wraps_d;
`ifdef RIPPLE_SEQ_CHECK_EN
      step_err_q  <= step_err_d;
`endif
    end
  end

  // Fixed 8-bit view of the wrap counter for the two wrap digits.
  assign wraps_8 = 8'(wraps_q);

  assign mon.count_out   = count_out_q;
  assign mon.new_val     = new_val_q;
  assign mon.wraps       = wraps_q;
`ifdef RIPPLE_SEQ_CHECK_EN
  assign mon.step_err    = step_err_q;
`else
  assign mon.step_err    = 1'b0;
`endif
  assign mon.hex_count   = hex7(4'(count_out_q));
  assign mon.hex_wrap_lo = hex7(wraps_8[3:0]);
  assign mon.hex_wrap_hi = hex7(wraps_8[7:4]);

endmodule

// File: tb/tb_ripple_count_monitor.sv
// tb_ripple_count_monitor
// Self-checking bench for ripple_count_monitor. A behavioural model tracks
// how long the synchronized value has been steady (a run length), decides
// accepts from that, and a compare process checks every DUT output against
// the model on each falling edge. Directed phases pin the model with
// hand-computed literal expectations; a randomized phase follows.

module tb_ripple_count_monitor;
  localparam int WIDTH  = 4;
  localparam int S      = 4;
  localparam int WRAP_W = 8;
`ifdef RIPPLE_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ripple_count_monitor_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) mon_if ();

  ripple_count_monitor #(
    .WIDTH(WIDTH), .STABLE_CYCLES(S), .WRAP_W(WRAP_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mon  (mon_if)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tab [16];
  logic [3:0] m_s1, m_s2;      // two-sample delay of count_in
  logic [3:0] run_val;         // value of the current steady run
  int         run_len;         // length of that run in sampled edges
  logic [3:0] m_count;
  logic       m_new, m_primed, m_err;
  logic [7:0] m_wraps;
  logic       model_ok = 1'b0;
  logic [3:0] exp_q[$];        // accepted values awaiting a DUT strobe

  task automatic model_step();
    logic [3:0] x;
    logic       acc;
    if (!reset) begin
      m_s1 = 4'h0; m_s2 = 4'h0;
      // Reset leaves the filter as if a 0 had just been captured.
      run_val = 4'h0; run_len = 1;
      m_count = 4'h0; m_new = 1'b0; m_primed = 1'b0; m_err = 1'b0;
      m_wraps = 8'h00;
      exp_q.delete();
      model_ok = 1'b1;
    end else begin
      x = m_s2;
      m_s2 = m_s1;
      m_s1 = mon_if.count_in;
      if (x == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = x;
        run_len = 1;
      end
      acc = (run_len >= S + 1) && (!m_primed || x != m_count);
      m_new = acc;
      if (acc) begin
        if (m_primed) begin
          if (m_count == 4'hF && x == 4'h0) m_wraps = m_wraps + 8'd1;
          if (SEQ_EN && x != 4'(m_count + 4'd1)) m_err = 1'b1;
        end
        m_count  = x;
        m_primed = 1'b1;
        exp_q.push_back(x);
      end
      if (mon_if.clr) begin
        m_wraps = 8'h00;
        m_err   = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- scoreboard / compare ----------------
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("count_out",   mon_if.count_out,   m_count);
      chk("new_val",     mon_if.new_val,     m_new);
      chk("wraps",       mon_if.wraps,       m_wraps);
      chk("step_err",    mon_if.step_err,    m_err);
      chk("hex_count",   mon_if.hex_count,   hex_tab[m_count]);
      chk("hex_wrap_lo", mon_if.hex_wrap_lo, hex_tab[m_wraps[3:0]]);
      chk("hex_wrap_hi", mon_if.hex_wrap_hi, hex_tab[m_wraps[7:4]]);
      if (mon_if.new_val) begin
        if (exp_q.size() == 0) chk("accept_queue_empty", 32'd0, 32'd1);
        else chk("accept_value", mon_if.count_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    mon_if.count_in = v;
    repeat (n) cyc();
  endtask

  // ---------------- stimulus ----------------
  int         pulses, pulse_edge, saw2;
  logic [3:0] v, last_v;

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
    hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
    hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
    hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;

    // Reset for two edges with a nonzero input.
    mon_if.count_in = 4'h9;
    mon_if.clr      = 1'b0;
    reset           = 1'b0;
    cyc(); cyc();
    chk("rst_count_out", mon_if.count_out, 4'h0);
    chk("rst_wraps",     mon_if.wraps,     8'h00);
    chk("rst_new_val",   mon_if.new_val,   1'b0);
    chk("rst_hex_count", mon_if.hex_count, 7'b1000000);

    // Steady 3 after reset: a single pulse on edge 7.
    mon_if.count_in = 4'h3;
    reset = 1'b1;
    pulses = 0; pulse_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (mon_if.new_val) begin pulses++; pulse_edge = i; end
    end
    chk("t1_pulses",    pulses,           1);
    chk("t1_edge",      pulse_edge,       7);
    chk("t1_count_out", mon_if.count_out, 4'h3);
    chk("t1_step_err",  mon_if.step_err,  1'b0);

    // Short glitch to 2 is rejected, then 4 is accepted on edge 7.
    saw2 = 0;
    mon_if.count_in = 4'h2;
    repeat (3) begin cyc(); if (mon_if.new_val) saw2++; end
    mon_if.count_in = 4'h4;
    pulses = 0; pulse_edge = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (mon_if.new_val) begin pulses++; pulse_edge = i; end
      if (mon_if.count_out == 4'h2) saw2++;
    end
    chk("t2_pulses",    pulses,           1);
    chk("t2_edge",      pulse_edge,       7);
    chk("t2_count_out", mon_if.count_out, 4'h4);
    chk("t2_no_two",    saw2,             0);
    chk("t2_step_err",  mon_if.step_err,  1'b0);

    // Fresh start, then walk 0..F and back to 0.
    reset = 1'b0; cyc(); reset = 1'b1;
    pulses = 0;
    for (int k = 0; k <= 16; k++) begin
      mon_if.count_in = 4'(k);
      repeat (20) begin cyc(); if (mon_if.new_val) pulses++; end
    end
    chk("t3_pulses",      pulses,             17);
    chk("t3_wraps",       mon_if.wraps,       8'h01);
    chk("t3_hex_wrap_lo", mon_if.hex_wrap_lo, 7'b1111001);
    chk("t3_step_err",    mon_if.step_err,    1'b0);

    // Walk to 5, jump to 7, then clr coinciding with the accept of 8.
    for (int k = 1; k <= 5; k++) hold(4'(k), 20);
    chk("t4_count_out5", mon_if.count_out, 4'h5);
    chk("t4_err_before", mon_if.step_err,  1'b0);
    hold(4'h7, 20);
    chk("t4_err_set",    mon_if.step_err,  SEQ_EN);
    hold(4'h7, 20);
    chk("t4_err_sticky", mon_if.step_err,  SEQ_EN);
    mon_if.count_in = 4'h8;
    repeat (6) cyc();
    mon_if.clr = 1'b1;
    cyc();
    mon_if.clr = 1'b0;
    chk("t4_clr_new_val",   mon_if.new_val,   1'b1);
    chk("t4_clr_count_out", mon_if.count_out, 4'h8);
    chk("t4_clr_step_err",  mon_if.step_err,  1'b0);
    chk("t4_clr_wraps",     mon_if.wraps,     8'h00);
    repeat (10) cyc();

    // 255 wraps, then one more rolls the counter over.
    for (int k = 0; k < 255; k++) begin
      hold(4'hF, 6);
      hold(4'h0, 6);
    end
    repeat (10) cyc();
    chk("t5_wraps_ff",  mon_if.wraps,       8'hFF);
    chk("t5_hex_hi_f",  mon_if.hex_wrap_hi, 7'b0001110);
    chk("t5_hex_lo_f",  mon_if.hex_wrap_lo, 7'b0001110);
    hold(4'hF, 12);
    hold(4'h0, 12);
    chk("t5_wraps_00",  mon_if.wraps,       8'h00);
    chk("t5_hex_lo_0",  mon_if.hex_wrap_lo, 7'b1000000);
    hold(4'hF, 12);
    hold(4'h0, 12);
    chk("t5_wraps_01",  mon_if.wraps,       8'h01);

    // Reset in the middle of filtering a new value.
    hold(4'h6, 4);
    reset = 1'b0;
    cyc();
    chk("t6_count_out", mon_if.count_out,   4'h0);
    chk("t6_new_val",   mon_if.new_val,     1'b0);
    chk("t6_wraps",     mon_if.wraps,       8'h00);
    chk("t6_step_err",  mon_if.step_err,    1'b0);
    chk("t6_hex_count", mon_if.hex_count,   7'b1000000);
    chk("t6_hex_lo",    mon_if.hex_wrap_lo, 7'b1000000);
    chk("t6_hex_hi",    mon_if.hex_wrap_hi, 7'b1000000);
    reset = 1'b1;
    repeat (20) cyc();
    chk("t6_reaccept",  mon_if.count_out,   4'h6);

    // Randomized phase: mixes counting-up runs, random jumps, short
    // glitches, occasional clr and occasional reset.
    last_v = 4'h6;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 2) != 0) v = last_v + 4'd1;
      else v = 4'($urandom_range(0, 15));
      last_v = v;
      mon_if.count_in = v;
      mon_if.clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) reset = 1'b0;
      repeat ($urandom_range(1, 9)) begin
        cyc();
        mon_if.clr = 1'b0;
        reset = 1'b1;
      end
    end
    repeat (12) cyc();
    chk("end_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
